// File: rtl/fetch_pc_if.sv
// fetch_pc_if: redirect, instruction-memory and decode-side signals of the fetch stage.
interface fetch_pc_if;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        instValid;
    logic [31:0] instData;
    logic [31:0] instPC;
    logic        instReady;
    logic        fetchMisaligned;
    modport master (
        input  redirectValid, redirectPC, imemReqReady, imemRespValid, imemRespData, instReady,
        output imemReqValid, imemReqAddr, instValid, instData, instPC, fetchMisaligned
    );
    modport slave (
        output redirectValid, redirectPC, imemReqReady, imemRespValid, imemRespData, instReady,
        input  imemReqValid, imemReqAddr, instValid, instData, instPC, fetchMisaligned
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register and single-outstanding instruction fetch feeding a 2-entry decode queue.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input logic        clk,
    input logic        rst_n,
    fetch_pc_if.master bus
);
    typedef enum logic [1:0] {REQ, WAIT, FLUSH, HALT} state_t;
    state_t      state, state_nxt;
    logic [31:0] pc, req_pc;
    logic [31:0] q_pc [2];
    logic [31:0] q_data [2];
    logic [1:0]  count;
    logic        halt_pend, halt_pend_nxt, misaligned;
    logic        hs, pop, push, redir_ok, redir_bad, pending, wr0, wr1, shift;
    assign bus.imemReqValid    = rst_n && state == REQ && count < 2'(QDEPTH);
    assign bus.imemReqAddr     = pc;
    assign bus.instValid       = count != 2'd0;
    assign bus.instData        = q_data[0];
    assign bus.instPC          = q_pc[0];
    assign bus.fetchMisaligned = misaligned;
    assign hs        = bus.imemReqValid && bus.imemReqReady;
    assign pop       = bus.instValid && bus.instReady;
    assign redir_ok  = bus.redirectValid && bus.redirectPC[1:0] == 2'b00;
    assign redir_bad = bus.redirectValid && bus.redirectPC[1:0] != 2'b00;
    // a request is still in flight after this cycle: the redirect must discard its response
    assign pending   = (state == WAIT || state == FLUSH) ? !bus.imemRespValid : hs;
    assign push      = state == WAIT && bus.imemRespValid && !bus.redirectValid;
    assign wr0       = push && (count == 2'd0 || (count == 2'd1 && pop));
    assign wr1       = push && (count == 2'd2 || (count == 2'd1 && !pop));
    assign shift     = pop && count == 2'd2;
    always_comb begin
        state_nxt     = state;
        halt_pend_nxt = halt_pend;
        if (bus.redirectValid) begin
            state_nxt     = pending ? FLUSH : redir_ok ? REQ : HALT;
            halt_pend_nxt = redir_bad && pending;
        end else begin
            case (state)
                REQ:     state_nxt = hs ? WAIT : REQ;
                WAIT:    state_nxt = bus.imemRespValid ? REQ : WAIT;
                FLUSH: begin
                    state_nxt     = !bus.imemRespValid ? FLUSH : halt_pend ? HALT : REQ;
                    halt_pend_nxt = halt_pend && !bus.imemRespValid;
                end
                default: state_nxt = HALT;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= REQ;
            pc         <= RESET_PC;
            req_pc     <= '0;
            count      <= '0;
            halt_pend  <= 1'b0;
            misaligned <= 1'b0;
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
            q_data[0]  <= '0;
            q_data[1]  <= '0;
        end else begin
            state      <= state_nxt;
            halt_pend  <= halt_pend_nxt;
            misaligned <= redir_bad;
            pc         <= redir_ok ? bus.redirectPC : (hs && !bus.redirectValid) ? pc + 32'd4 : pc;
            req_pc     <= hs ? pc : req_pc;
            count      <= bus.redirectValid ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
            q_pc[0]    <= shift ? q_pc[1] : wr0 ? req_pc : q_pc[0];
            q_data[0]  <= shift ? q_data[1] : wr0 ? bus.imemRespData : q_data[0];
            q_pc[1]    <= wr1 ? req_pc : q_pc[1];
            q_data[1]  <= wr1 ? bus.imemRespData : q_data[1];
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scenarios plus randomized run against a queue-based fetch model.
module tb_fetch_pc_unit;
    localparam logic [31:0] RPC = 32'h100;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    fetch_pc_if bus();
    fetch_pc_unit #(.RESET_PC(RPC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0;
    int passes = 0;
    bit          mem_on;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          lat = 1;
    bit          last_hs;
    logic [31:0] last_addr;
    logic [31:0] m_pc, m_reqpc;
    bit          m_out, m_discard, m_halted, m_halt_after, m_mis;
    logic [63:0] m_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic bit m_req_valid();
        return !m_out && !m_halted && m_q.size() < 2;
    endfunction

    function automatic void m_reset();
        m_pc = RPC;
        m_reqpc = '0;
        m_out = 0;
        m_discard = 0;
        m_halted = 0;
        m_halt_after = 0;
        m_mis = 0;
        m_q.delete();
    endfunction

    // one cycle of the fetch rules, using the inputs currently on the bus
    function automatic void m_step();
        bit hs, pop, still;
        hs = m_req_valid() && bus.imemReqReady;
        pop = m_q.size() > 0 && bus.instReady;
        m_mis = 0;
        if (bus.redirectValid) begin
            still = m_out ? !bus.imemRespValid : hs;
            m_q.delete();
            m_out = still;
            m_discard = still;
            if (bus.redirectPC[1:0] == 2'b00) begin
                m_pc = bus.redirectPC;
                m_halted = 0;
                m_halt_after = 0;
            end else begin
                m_mis = 1;
                m_halt_after = still;
                m_halted = !still;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_out && bus.imemRespValid) begin
                if (!m_discard) m_q.push_back({m_reqpc, bus.imemRespData});
                if (m_discard && m_halt_after) m_halted = 1;
                m_out = 0;
                m_discard = 0;
                m_halt_after = 0;
            end
            if (hs) begin
                m_reqpc = m_pc;
                m_pc = m_pc + 32'd4;
                m_out = 1;
            end
        end
    endfunction

    // advance one clock; the memory answers each accepted request after lat cycles
    task automatic tick();
        last_hs = bus.imemReqValid && bus.imemReqReady;
        last_addr = bus.imemReqAddr;
        m_step();
        @(posedge clk);
        @(negedge clk);
        bus.redirectValid = 1'b0;
        bus.imemRespValid = 1'b0;
        if (last_hs) begin
            mem_on = 1;
            mem_wait = lat - 1;
            mem_addr = last_addr;
        end
        if (mem_on) begin
            if (mem_wait == 0) begin
                bus.imemRespValid = 1'b1;
                bus.imemRespData = inst_of(mem_addr);
                mem_on = 0;
            end else mem_wait--;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirectValid = 1'b0;
        bus.redirectPC = '0;
        bus.imemReqReady = 1'b1;
        bus.imemRespValid = 1'b0;
        bus.imemRespData = '0;
        bus.instReady = 1'b1;
        mem_on = 0;
        lat = 1;
        @(negedge clk);
        @(negedge clk);
        m_reset();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.redirectValid = 1'b0;
        bus.redirectPC = '0;
        bus.imemReqReady = 1'b1;
        bus.imemRespValid = 1'b0;
        bus.imemRespData = '0;
        bus.instReady = 1'b1;
        #12;
        checks++;
        if (bus.imemReqValid !== 1'b0) $display("FAIL reset_reqvalid: got %b want 0", bus.imemReqValid);
        else passes++;
        checks++;
        if (bus.instValid !== 1'b0 || bus.instData !== 32'h0 || bus.instPC !== 32'h0)
            $display("FAIL reset_inst: got v=%b d=%h pc=%h want 0/0/0", bus.instValid, bus.instData, bus.instPC);
        else passes++;
        checks++;
        if (bus.fetchMisaligned !== 1'b0) $display("FAIL reset_misaligned: got %b want 0", bus.fetchMisaligned);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.imemReqValid !== 1'b1 || bus.imemReqAddr !== RPC)
            $display("FAIL reset_first_req: got v=%b a=%h want 1/%h", bus.imemReqValid, bus.imemReqAddr, RPC);
        else passes++;
    endtask

    task automatic test_sequential();
        logic [31:0] reqs[$], pcs[$], datas[$];
        bit prev_resp;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (bus.instValid) begin
                pcs.push_back(bus.instPC);
                datas.push_back(bus.instData);
            end
            prev_resp = bus.imemRespValid;
            tick();
            if (last_hs) reqs.push_back(last_addr);
            if (prev_resp) begin
                checks++;
                if (bus.instValid !== 1'b1) $display("FAIL seq_latency: cycle %0d instValid %b want 1", i, bus.instValid);
                else passes++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= reqs.size() || reqs[k] !== RPC + 32'(4 * k))
                $display("FAIL seq_addr%0d: got %h want %h", k, k < reqs.size() ? reqs[k] : 32'hx, RPC + 32'(4 * k));
            else passes++;
            checks++;
            if (k >= pcs.size() || pcs[k] !== RPC + 32'(4 * k) || datas[k] !== inst_of(RPC + 32'(4 * k)))
                $display("FAIL seq_inst%0d: got pc=%h d=%h want pc=%h d=%h", k, k < pcs.size() ? pcs[k] : 32'hx,
                         k < datas.size() ? datas[k] : 32'hx, RPC + 32'(4 * k), inst_of(RPC + 32'(4 * k)));
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] reqs[$], pcs[$];
        do_reset();
        bus.instReady = 1'b0;
        repeat (8) tick();
        checks++;
        if (bus.instValid !== 1'b1 || bus.instPC !== RPC || bus.instData !== inst_of(RPC))
            $display("FAIL bp_head: got v=%b pc=%h d=%h want 1/%h/%h", bus.instValid, bus.instPC, bus.instData, RPC, inst_of(RPC));
        else passes++;
        checks++;
        if (bus.imemReqValid !== 1'b0) $display("FAIL bp_credit: got reqValid %b want 0", bus.imemReqValid);
        else passes++;
        bus.instReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.instValid) pcs.push_back(bus.instPC);
            tick();
            if (last_hs) reqs.push_back(last_addr);
        end
        checks++;
        if (pcs.size() < 2 || pcs[0] !== RPC || pcs[1] !== RPC + 32'd4)
            $display("FAIL bp_pop_order: got %0d pops first %h want %h then %h", pcs.size(), pcs.size() > 0 ? pcs[0] : 32'hx, RPC, RPC + 32'd4);
        else passes++;
        checks++;
        if (reqs.size() < 1 || reqs[0] !== RPC + 32'd8)
            $display("FAIL bp_resume: got %h want %h", reqs.size() > 0 ? reqs[0] : 32'hx, RPC + 32'd8);
        else passes++;
    endtask

    task automatic test_redirect_wait();
        logic [31:0] reqs[$];
        logic [31:0] first_pc;
        bit found, bad, seen;
        do_reset();
        lat = 2;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = last_hs && last_addr == RPC + 32'd4;
        end
        checks++;
        if (!found) $display("FAIL rw_reach: no request at %h seen, want one", RPC + 32'd4);
        else passes++;
        bus.redirectValid = 1'b1;
        bus.redirectPC = 32'h2000;
        tick();
        checks++;
        if (bus.instValid !== 1'b0) $display("FAIL rw_flush: got instValid %b want 0", bus.instValid);
        else passes++;
        bad = 0;
        seen = 0;
        first_pc = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.instValid && bus.instPC === RPC + 32'd4) bad = 1;
            if (bus.instValid && !seen) begin
                seen = 1;
                first_pc = bus.instPC;
            end
            tick();
            if (last_hs) reqs.push_back(last_addr);
        end
        checks++;
        if (bad) $display("FAIL rw_stale: got instPC %h delivered want dropped", RPC + 32'd4);
        else passes++;
        checks++;
        if (reqs.size() < 1 || reqs[0] !== 32'h2000)
            $display("FAIL rw_target: got %h want 00002000", reqs.size() > 0 ? reqs[0] : 32'hx);
        else passes++;
        checks++;
        if (!seen || first_pc !== 32'h2000) $display("FAIL rw_first_inst: got %h want 00002000", first_pc);
        else passes++;
    endtask

    task automatic test_redirect_handshake();
        logic [31:0] reqs[$];
        bit found, bad;
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.imemReqValid && bus.imemReqAddr === RPC + 32'd8) found = 1;
            else tick();
        end
        checks++;
        if (!found) $display("FAIL rh_reach: no request at %h seen, want one", RPC + 32'd8);
        else passes++;
        bus.redirectValid = 1'b1;
        bus.redirectPC = 32'h3000;
        tick();
        checks++;
        if (!last_hs || bus.imemReqValid !== 1'b0)
            $display("FAIL rh_flush: got hs=%b reqValid=%b want 1/0", last_hs, bus.imemReqValid);
        else passes++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.instValid && bus.instPC === RPC + 32'd8) bad = 1;
            tick();
            if (last_hs) reqs.push_back(last_addr);
        end
        checks++;
        if (bad) $display("FAIL rh_stale: got instPC %h delivered want dropped", RPC + 32'd8);
        else passes++;
        checks++;
        if (reqs.size() < 1 || reqs[0] !== 32'h3000)
            $display("FAIL rh_target: got %h want 00003000", reqs.size() > 0 ? reqs[0] : 32'hx);
        else passes++;
    endtask

    task automatic test_misaligned();
        bit saw;
        do_reset();
        tick();
        tick();
        bus.redirectValid = 1'b1;
        bus.redirectPC = 32'h2002;
        tick();
        checks++;
        if (bus.fetchMisaligned !== 1'b1) $display("FAIL mis_pulse: got %b want 1", bus.fetchMisaligned);
        else passes++;
        tick();
        checks++;
        if (bus.fetchMisaligned !== 1'b0) $display("FAIL mis_one_cycle: got %b want 0", bus.fetchMisaligned);
        else passes++;
        saw = 0;
        repeat (6) begin
            if (bus.imemReqValid || bus.instValid) saw = 1;
            tick();
        end
        checks++;
        if (saw) $display("FAIL mis_halt: got request or inst while halted want none");
        else passes++;
        bus.redirectValid = 1'b1;
        bus.redirectPC = 32'h4000;
        tick();
        checks++;
        if (bus.imemReqValid !== 1'b1 || bus.imemReqAddr !== 32'h4000)
            $display("FAIL mis_resume: got v=%b a=%h want 1/00004000", bus.imemReqValid, bus.imemReqAddr);
        else passes++;
    endtask

    task automatic test_wrap_reset();
        logic [31:0] reqs[$], pcs[$];
        do_reset();
        bus.imemReqReady = 1'b0;
        bus.redirectValid = 1'b1;
        bus.redirectPC = 32'hFFFF_FFFC;
        tick();
        bus.imemReqReady = 1'b1;
        lat = 3;
        checks++;
        if (bus.imemReqValid !== 1'b1 || bus.imemReqAddr !== 32'hFFFF_FFFC)
            $display("FAIL wr_top_req: got v=%b a=%h want 1/fffffffc", bus.imemReqValid, bus.imemReqAddr);
        else passes++;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.imemReqValid !== 1'b0 || bus.instValid !== 1'b0 || bus.imemReqAddr !== RPC)
            $display("FAIL wr_async_clear: got v=%b iv=%b a=%h want 0/0/%h", bus.imemReqValid, bus.instValid, bus.imemReqAddr, RPC);
        else passes++;
        bus.imemReqReady = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.instValid !== 1'b0) $display("FAIL wr_late_resp: got instValid %b want 0", bus.instValid);
        else passes++;
        checks++;
        if (bus.imemReqValid !== 1'b1 || bus.imemReqAddr !== RPC)
            $display("FAIL wr_after_reset: got v=%b a=%h want 1/%h", bus.imemReqValid, bus.imemReqAddr, RPC);
        else passes++;
        do_reset();
        bus.imemReqReady = 1'b0;
        bus.redirectValid = 1'b1;
        bus.redirectPC = 32'hFFFF_FFFC;
        tick();
        bus.imemReqReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.instValid) pcs.push_back(bus.instPC);
            tick();
            if (last_hs) reqs.push_back(last_addr);
        end
        checks++;
        if (reqs.size() < 2 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0)
            $display("FAIL wr_wrap_addr: got %0d reqs second %h want fffffffc then 00000000", reqs.size(), reqs.size() > 1 ? reqs[1] : 32'hx);
        else passes++;
        checks++;
        if (pcs.size() < 2 || pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0)
            $display("FAIL wr_wrap_inst: got %0d insts second %h want fffffffc then 00000000", pcs.size(), pcs.size() > 1 ? pcs[1] : 32'hx);
        else passes++;
    endtask

    task automatic test_random();
        bit ev;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bus.imemReqReady = $urandom_range(0, 3) != 0;
            bus.instReady = $urandom_range(0, 2) != 0;
            lat = $urandom_range(1, 3);
            if ($urandom_range(0, 11) == 0) begin
                bus.redirectValid = 1'b1;
                bus.redirectPC = ($urandom & 32'h0000_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            end
            ev = m_req_valid();
            checks++;
            if (bus.imemReqValid !== ev || (ev && bus.imemReqAddr !== m_pc) || bus.instValid !== (m_q.size() > 0) ||
                (m_q.size() > 0 && {bus.instPC, bus.instData} !== m_q[0]) || bus.fetchMisaligned !== m_mis)
                $display("FAIL rand_cycle%0d: got rv=%b a=%h iv=%b pc=%h d=%h mis=%b want rv=%b a=%h iv=%b head=%h mis=%b",
                         i, bus.imemReqValid, bus.imemReqAddr, bus.instValid, bus.instPC, bus.instData, bus.fetchMisaligned,
                         ev, m_pc, m_q.size() > 0, m_q.size() > 0 ? m_q[0] : 64'h0, m_mis);
            else passes++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_handshake();
        test_misaligned();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter register and instruction-fetch stage. It sits directly downstream of the JAL target/link computation and upstream of decode. It owns the architectural PC and issues one-outstanding fetch requests to instruction memory. It accepts redirects whose target comes from the JAL unit's updated PC, buffers returned instructions with their PC in a 2-entry queue, and drops stale responses after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
QDEPTH, 2, output queue depth in {PC, instruction} entries; fixed at 2.

Ports:
clk  input  1  single clock; all state is rising-edge.
rst_n  input  1  reset, asynchronous, active-low.
redirectValid  input  1  one-cycle redirect strobe; driven by JAL taken.
redirectPC  input  32  redirect target; the JAL unit's updated PC.
imemReqValid  output  1  fetch request valid.
imemReqAddr  output  32  fetch address; equals the current PC.
imemReqReady  input  1  memory accepts the request.
imemRespValid  input  1  fetch response valid; one cycle per response, no backpressure.
imemRespData  input  32  fetched instruction.
instValid  output  1  queue head valid toward decode.
instData  output  32  queue head instruction.
instPC  output  32  PC of queue head instruction.
instReady  input  1  decode consumes the head.
fetchMisaligned  output  1  registered one-cycle pulse on a redirect target with bits[1:0] != 0.

Behaviour:
- Reset (async assert, rst_n=0):
  - pc=RESET_PC; state=REQ; queue empty; reqPC=0.
  - imemReqValid=0, instValid=0, instData=0, instPC=0, fetchMisaligned=0.
- States:
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - FLUSH: outstanding response must be discarded.
  - HALT: stopped after a misaligned redirect.
- Credit rule: imemReqValid=1 only in REQ and when (queue count) < QDEPTH. The queue count does not include the outstanding request, because issue is only allowed with no request outstanding.
- Request handshake:
  - When imemReqValid && imemReqReady: reqPC<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC to 0), state->WAIT.
  - While imemReqValid && !imemReqReady, imemReqAddr stays stable. The only exception is a redirect.
- Response:
  - In WAIT with imemRespValid: push {reqPC, imemRespData} and go to REQ.
  - In FLUSH: drop the response and go to REQ.
  - In REQ or HALT: imemRespValid is ignored (no outstanding request, e.g. after reset).
- Queue:
  - 2-entry FIFO with registered outputs. instValid is high when the queue is non-empty.
  - Pop when instValid && instReady. Simultaneous push and pop keeps the count unchanged.
  - A push into a full queue cannot occur by the credit rule.
- Latency:
  - Response at cycle N gives instValid=1 at N+1.
  - First request is asserted in the first cycle after rst_n deasserts.
- Redirect, aligned target (redirectValid && redirectPC[1:0]==0), highest priority in every state:
  - pc<=redirectPC; queue flushed (count=0, instValid=0 next cycle). A same-cycle pop is ignored and a same-cycle push is dropped.
  - Next state:
    - FLUSH if in WAIT without a same-cycle response.
    - FLUSH if in REQ with a same-cycle handshake (pc is still set to redirectPC, not redirectPC+4).
    - REQ otherwise, including WAIT with a same-cycle response (response dropped) and FLUSH with a same-cycle response.
    - FLUSH if in FLUSH without a response.
    - REQ if in HALT.
  - From REQ with no outstanding request, imemReqAddr=redirectPC on cycle N+1.
- Redirect, misaligned target:
  - fetchMisaligned=1 for the next cycle only; pc is unchanged; queue flushed.
  - State->HALT, via FLUSH first if a request is outstanding (FLUSH then exits to HALT, not REQ). A flag records the pending halt.
  - HALT: no requests; leave only on an aligned redirect.
- Reset mid-operation: everything clears immediately; an in-flight memory response after reset is ignored per the response rules.

Test Plan:
- Reset release, RESET_PC=0x100, imemReqReady=1, memory returns data one cycle after each request, instReady=1 -> addresses 0x100, 0x104, 0x108; instPC/instData pairs in order; instValid one cycle after each response.
- instReady=0 held -> after 2 responses instValid=1, imemReqValid=0; raise instReady -> entries pop 0x100 then 0x104, then fetching resumes at 0x108.
- Redirect to 0x2000 while in WAIT for 0x104 -> response for 0x104 dropped; next request at 0x2000; queue empty until the 0x2000 response; no instPC=0x104 ever appears.
- Redirect to 0x3000 in the same cycle as a request handshake at 0x108 -> FLUSH; the 0x108 response is dropped; next request address is 0x3000, not 0x3004.
- Redirect to 0x2002 -> fetchMisaligned pulses exactly one cycle; imemReqValid stays 0; aligned redirect to 0x4000 -> request at 0x4000 next cycle.
- pc=0xFFFF_FFFC fetch, then rst_n pulled low mid-WAIT -> outputs clear immediately; after release the request is at RESET_PC; a late imemRespValid is ignored. A separate run without reset confirms the address after 0xFFFF_FFFC wraps to 0x0.
